cla_multiword_seq: RTL

//  Multi-precision add/subtract sequencer around one shared 8-bit CLA adder.

---
 rtl/cla_multiword_seq_pkg.sv | 33 +++
 rtl/cla_multiword_seq_cla8.sv | 25 ++
 rtl/cla_multiword_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cla_multiword_seq_pkg.sv
// Shared types and helpers for the multi-word CLA add/subtract sequencer.
package cla_multiword_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sum-of-products lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0
  function automatic logic [BYTE_W:0] cla_carries(input logic [BYTE_W-1:0] g,
                                                  input logic [BYTE_W-1:0] p,
                                                  input logic c0);
    logic [BYTE_W:0] c;
    logic acc;
    logic prod;
    c = {(BYTE_W+1){1'b0}};
    c[0] = c0;
    for (int i = 0; i < BYTE_W; i++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (g[j] & prod);
        prod = prod & p[j];
      end
      c[i+1] = acc | (c0 & prod);
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_multiword_seq_cla8.sv
// 8-bit carry-lookahead adder; the only arithmetic path of the sequencer.
module cla_multiword_seq_cla8
  import cla_multiword_seq_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  // Generate/propagate, lookahead carries, then sum bits
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = cla_carries(g, p, cin);
    sum  = p ^ c[7:0];
    cout = c[8];
  end

endmodule

// File: rtl/cla_multiword_seq.sv
// Multi-precision add/subtract: streams NBYTES-wide operands through one
// shared 8-bit CLA adder, LSB byte first, with the carry held in a register.
module cla_multiword_seq
  import cla_multiword_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_t          state_r;
  state_t          next_state;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            carry_r;
  logic [IDXW-1:0] idx_r;
  logic [7:0]      byte_a;
  logic [7:0]      byte_b;
  logic [7:0]      byte_sum;
  logic            byte_cout;
  logic            last_byte;
  logic            accept;

  assign byte_a    = a_r[BYTE_W*idx_r +: BYTE_W];
  assign byte_b    = b_r[BYTE_W*idx_r +: BYTE_W];
  assign last_byte = (idx_r == LAST_IDX);
  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign accept    = in_valid & in_ready;

  cla_multiword_seq_cla8 u_cla8 (
    .a    (byte_a),
    .b    (byte_b),
    .cin  (carry_r),
    .sum  (byte_sum),
    .cout (byte_cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept) next_state = ST_RUN;
        else        next_state = ST_IDLE;
      end
      ST_RUN: begin
        if (last_byte) next_state = ST_DONE;
        else           next_state = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) next_state = ST_IDLE;
        else           next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand capture, per-byte accumulation and final flag registration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDXW{1'b0}};
      result  <= {W{1'b0}};
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept) begin
            a_r     <= a;
            // Subtract is a + ~b + 1: invert here, inject the 1 as carry-in
            b_r     <= op_sub ? ~b : b;
            carry_r <= op_sub;
            idx_r   <= {IDXW{1'b0}};
            result  <= {W{1'b0}};
          end
        end
        ST_RUN: begin
          result[BYTE_W*idx_r +: BYTE_W] <= byte_sum;
          carry_r <= byte_cout;
          if (last_byte) begin
            idx_r <= {IDXW{1'b0}};
            cout  <= byte_cout;
            ovf   <= (a_r[W-1] == b_r[W-1]) & (byte_sum[7] != a_r[W-1]);
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        ST_DONE: begin
          carry_r <= carry_r;
        end
        default: begin
          carry_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
